// File: rtl/mixed_precision_csr.sv
// Mixed-precision CSR block: MIXCYCLE (0x00D), SKIPSIZE (0x00E), IVECFMT (0x00F).
// This is the storage end of the mixed-precision controller's cycle update path.
// It also provides the EX-stage sub-word select used by the dotp operand slicer.
module mixed_precision_csr #(
  parameter int NBITS_MIXED_CYCLES = 3,
  parameter int NBITS_MAX_KER      = 8,
  parameter int FMT_W              = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          setback_i,
  input  logic [1:0]                    csr_op_i,
  input  logic [11:0]                   csr_addr_i,
  input  logic [31:0]                   csr_wdata_i,
  output logic [31:0]                   csr_rdata_o,
  input  logic                          hw_we_i,
  input  logic [NBITS_MIXED_CYCLES-1:0] hw_next_cycle_i,
  input  logic                          id_valid_i,
  input  logic                          ex_ready_i,
  output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
  output logic [NBITS_MAX_KER-1:0]      skip_size_o,
  output logic [FMT_W-1:0]              ivec_fmt_o,
  output logic [NBITS_MIXED_CYCLES-1:0] ex_cycle_o
);

  localparam logic [11:0] ADDR_MIXCYCLE = 12'h00D;
  localparam logic [11:0] ADDR_SKIPSIZE = 12'h00E;
  localparam logic [11:0] ADDR_IVECFMT  = 12'h00F;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  csr_op_e op;
  assign op = csr_op_e'(csr_op_i);

  logic [NBITS_MIXED_CYCLES-1:0] cycle_q, cycle_d;
  logic [NBITS_MAX_KER-1:0]      skip_q, skip_d;
  logic [FMT_W-1:0]              fmt_q, fmt_d;
  logic [NBITS_MIXED_CYCLES-1:0] ex_cycle_q, ex_cycle_d;

  logic [NBITS_MIXED_CYCLES-1:0] cycle_mask;
  logic [31:0]                   rdata;
  logic [31:0]                   op_result;
  logic [NBITS_MAX_KER-1:0]      skip_wval;
  logic                          sw_hit, we_cycle, we_skip, we_fmt;

  // Bits of the op result above the widest register are truncated away on purpose.
  logic unused_op_result;
  assign unused_op_result = ^op_result;

  // Cycle mask derived from the current ivec format (reserved code 7 acts as "none").
  always_comb begin
    cycle_mask = '0;
    case (fmt_q)
      FMT_W'(1), FMT_W'(2), FMT_W'(3): cycle_mask = NBITS_MIXED_CYCLES'(1);
      FMT_W'(4), FMT_W'(5):            cycle_mask = NBITS_MIXED_CYCLES'(3);
      FMT_W'(6):                       cycle_mask = NBITS_MIXED_CYCLES'(7);
      default:                         cycle_mask = '0;
    endcase
  end

  // Read mux over current register contents; no bypass of same-cycle writes.
  always_comb begin
    rdata = '0;
    case (csr_addr_i)
      ADDR_MIXCYCLE: rdata = 32'(cycle_q);
      ADDR_SKIPSIZE: rdata = 32'(skip_q);
      ADDR_IVECFMT:  rdata = 32'(fmt_q);
      default:       rdata = '0;
    endcase
  end

  // Software op result, computed from the addressed register's current value.
  always_comb begin
    op_result = rdata;
    case (op)
      OP_WRITE: op_result = csr_wdata_i;
      OP_SET:   op_result = rdata | csr_wdata_i;
      OP_CLEAR: op_result = rdata & ~csr_wdata_i;
      default:  op_result = rdata;
    endcase
  end

  assign sw_hit   = (op != OP_NONE);
  assign we_cycle = sw_hit && (csr_addr_i == ADDR_MIXCYCLE);
  assign we_skip  = sw_hit && (csr_addr_i == ADDR_SKIPSIZE);
  assign we_fmt   = sw_hit && (csr_addr_i == ADDR_IVECFMT);

  assign skip_wval = op_result[NBITS_MAX_KER-1:0];

  // Next-state selection: software access beats setback, which beats the hw strobe.
  // An IVECFMT access counts as a software write of 0 to MIXCYCLE.
  always_comb begin
    cycle_d    = cycle_q;
    skip_d     = skip_q;
    fmt_d      = fmt_q;
    ex_cycle_d = ex_cycle_q;

    if (we_cycle)       cycle_d = op_result[NBITS_MIXED_CYCLES-1:0] & cycle_mask;
    else if (we_fmt)    cycle_d = '0;
    else if (setback_i) cycle_d = '0;
    else if (hw_we_i)   cycle_d = hw_next_cycle_i & cycle_mask;

    if (we_skip) skip_d = (skip_wval == '0) ? NBITS_MAX_KER'(1) : skip_wval;

    if (we_fmt) fmt_d = op_result[FMT_W-1:0];

    if (setback_i)                      ex_cycle_d = '0;
    else if (id_valid_i && ex_ready_i)  ex_cycle_d = cycle_q;
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q    <= '0;
      skip_q     <= NBITS_MAX_KER'(1);
      fmt_q      <= '0;
      ex_cycle_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      skip_q     <= skip_d;
      fmt_q      <= fmt_d;
      ex_cycle_q <= ex_cycle_d;
    end
  end

  assign csr_rdata_o     = rdata;
  assign current_cycle_o = cycle_q;
  assign skip_size_o     = skip_q;
  assign ivec_fmt_o      = fmt_q;
  assign ex_cycle_o      = ex_cycle_q;

endmodule

// File: tb/tb_mixed_precision_csr.sv
// Directed self-checking bench for mixed_precision_csr.
module tb_mixed_precision_csr;

  logic        clk;
  logic        rst_n;
  logic        setback;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        hw_we;
  logic [2:0]  hw_next;
  logic        id_valid;
  logic        ex_ready;
  logic [2:0]  current_cycle;
  logic [7:0]  skip_size;
  logic [2:0]  ivec_fmt;
  logic [2:0]  ex_cycle;

  int vectors;
  int miscompares;

  mixed_precision_csr #(
    .NBITS_MIXED_CYCLES(3),
    .NBITS_MAX_KER(8),
    .FMT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .setback_i(setback),
    .csr_op_i(csr_op),
    .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata),
    .hw_we_i(hw_we),
    .hw_next_cycle_i(hw_next),
    .id_valid_i(id_valid),
    .ex_ready_i(ex_ready),
    .current_cycle_o(current_cycle),
    .skip_size_o(skip_size),
    .ivec_fmt_o(ivec_fmt),
    .ex_cycle_o(ex_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OPN = 2'b00, OPW = 2'b01, OPS = 2'b10, OPC = 2'b11;
  localparam logic [11:0] A_CYC = 12'h00D, A_SKIP = 12'h00E, A_FMT = 12'h00F;

  task automatic sw(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    csr_op = op; csr_addr = addr; csr_wdata = data;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step;
    @(posedge clk);
    #1;
    csr_op = OPN; hw_we = 1'b0; setback = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr);
    csr_op = OPN; csr_addr = addr;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(A_CYC);
    vectors++; if (csr_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rd_cyc got %0h want 0", csr_rdata); end
    rd(A_SKIP);
    vectors++; if (csr_rdata !== 32'd1) begin miscompares++; $display("FAIL reset_rd_skip got %0h want 1", csr_rdata); end
    rd(A_FMT);
    vectors++; if (csr_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rd_fmt got %0h want 0", csr_rdata); end
    vectors++; if (current_cycle !== 3'd0 || skip_size !== 8'd1 || ivec_fmt !== 3'd0 || ex_cycle !== 3'd0) begin
      miscompares++; $display("FAIL reset_outs got %0d/%0d/%0d/%0d want 0/1/0/0", current_cycle, skip_size, ivec_fmt, ex_cycle);
    end
  endtask

  task automatic test_hw_cycle;
    sw(OPW, A_FMT, 32'd6); step();
    vectors++; if (ivec_fmt !== 3'd6) begin miscompares++; $display("FAIL hw_fmt got %0d want 6", ivec_fmt); end
    for (int k = 1; k <= 4; k++) begin
      hw_we = 1'b1; hw_next = 3'(k); step();
      rd(A_CYC);
      vectors++; if (csr_rdata !== 32'(k) || current_cycle !== 3'(k)) begin
        miscompares++; $display("FAIL hw_pulse%0d got %0d/%0d want %0d", k, csr_rdata, current_cycle, k);
      end
    end
  endtask

  task automatic test_cycle_mask;
    sw(OPW, A_FMT, 32'd1); step();
    sw(OPW, A_CYC, 32'd3); step();
    rd(A_CYC);
    vectors++; if (csr_rdata !== 32'd1) begin miscompares++; $display("FAIL mask_fmt1 got %0d want 1", csr_rdata); end
  endtask

  task automatic test_set_mask;
    sw(OPW, A_FMT, 32'd4); step();
    sw(OPS, A_CYC, 32'd4); step();
    rd(A_CYC);
    vectors++; if (csr_rdata !== 32'd0) begin miscompares++; $display("FAIL set_bit2_fmt4 got %0d want 0", csr_rdata); end
    sw(OPW, A_CYC, 32'd7); step();
    vectors++; if (current_cycle !== 3'd3) begin miscompares++; $display("FAIL write7_fmt4 got %0d want 3", current_cycle); end
  endtask

  task automatic test_priority;
    sw(OPW, A_FMT, 32'd5); step();
    sw(OPW, A_CYC, 32'd2); hw_we = 1'b1; hw_next = 3'd1; step();
    vectors++; if (current_cycle !== 3'd2) begin miscompares++; $display("FAIL sw_beats_hw got %0d want 2", current_cycle); end
    hw_we = 1'b1; hw_next = 3'd7; step();
    vectors++; if (current_cycle !== 3'd3) begin miscompares++; $display("FAIL hw_mask_fmt5 got %0d want 3", current_cycle); end
    sw(OPW, A_FMT, 32'd6); hw_we = 1'b1; hw_next = 3'd5; step();
    vectors++; if (current_cycle !== 3'd0 || ivec_fmt !== 3'd6) begin
      miscompares++; $display("FAIL fmt_write_clears got %0d/%0d want 0/6", current_cycle, ivec_fmt);
    end
  endtask

  task automatic test_setback;
    hw_we = 1'b1; hw_next = 3'd5; step();
    id_valid = 1'b1; ex_ready = 1'b1; step();
    vectors++; if (ex_cycle !== 3'd5) begin miscompares++; $display("FAIL sb_preload_ex got %0d want 5", ex_cycle); end
    setback = 1'b1; hw_we = 1'b1; hw_next = 3'd3; id_valid = 1'b1; ex_ready = 1'b1; step();
    vectors++; if (current_cycle !== 3'd0 || ex_cycle !== 3'd0) begin
      miscompares++; $display("FAIL setback_clear got %0d/%0d want 0/0", current_cycle, ex_cycle);
    end
    setback = 1'b1; sw(OPW, A_CYC, 32'd6); step();
    vectors++; if (current_cycle !== 3'd6) begin miscompares++; $display("FAIL setback_sw_write got %0d want 6", current_cycle); end
    vectors++; if (ivec_fmt !== 3'd6 || skip_size !== 8'd1) begin
      miscompares++; $display("FAIL setback_keeps got %0d/%0d want 6/1", ivec_fmt, skip_size);
    end
  endtask

  task automatic test_skipsize;
    sw(OPW, A_SKIP, 32'd0); step();
    rd(A_SKIP);
    vectors++; if (csr_rdata !== 32'd1) begin miscompares++; $display("FAIL skip_write0 got %0d want 1", csr_rdata); end
    sw(OPW, A_SKIP, 32'd5); step();
    vectors++; if (skip_size !== 8'd5) begin miscompares++; $display("FAIL skip_write5 got %0d want 5", skip_size); end
    sw(OPC, A_SKIP, 32'hFF); step();
    vectors++; if (skip_size !== 8'd1) begin miscompares++; $display("FAIL skip_clear_ff got %0d want 1", skip_size); end
    sw(OPS, A_SKIP, 32'h80); step();
    vectors++; if (skip_size !== 8'h81) begin miscompares++; $display("FAIL skip_set80 got %0h want 81", skip_size); end
    sw(OPW, A_SKIP, 32'h1FF); step();
    vectors++; if (skip_size !== 8'hFF) begin miscompares++; $display("FAIL skip_trunc got %0h want ff", skip_size); end
  endtask

  task automatic test_ex_cycle;
    sw(OPW, A_CYC, 32'd2); step();
    id_valid = 1'b1; ex_ready = 1'b1; step();
    vectors++; if (ex_cycle !== 3'd2) begin miscompares++; $display("FAIL ex_load got %0d want 2", ex_cycle); end
    sw(OPW, A_CYC, 32'd3); id_valid = 1'b1; ex_ready = 1'b0; step();
    vectors++; if (ex_cycle !== 3'd2 || current_cycle !== 3'd3) begin
      miscompares++; $display("FAIL ex_hold got %0d/%0d want 2/3", ex_cycle, current_cycle);
    end
    hw_we = 1'b1; hw_next = 3'd4; id_valid = 1'b1; ex_ready = 1'b1; step();
    vectors++; if (ex_cycle !== 3'd3 || current_cycle !== 3'd4) begin
      miscompares++; $display("FAIL ex_pre_update got %0d/%0d want 3/4", ex_cycle, current_cycle);
    end
  endtask

  task automatic test_back_to_back;
    sw(OPW, A_CYC, 32'd1);
    #1;
    vectors++; if (csr_rdata !== 32'd4) begin miscompares++; $display("FAIL no_bypass got %0d want 4", csr_rdata); end
    step();
    sw(OPW, A_CYC, 32'd5); step();
    sw(OPC, A_CYC, 32'd4); step();
    vectors++; if (current_cycle !== 3'd1) begin miscompares++; $display("FAIL b2b_clear got %0d want 1", current_cycle); end
  endtask

  task automatic test_unmapped;
    sw(OPW, 12'h010, 32'hFFFF_FFFF); step();
    vectors++; if (current_cycle !== 3'd1 || skip_size !== 8'hFF || ivec_fmt !== 3'd6) begin
      miscompares++; $display("FAIL unmapped_write got %0d/%0h/%0d want 1/ff/6", current_cycle, skip_size, ivec_fmt);
    end
    rd(12'h010);
    vectors++; if (csr_rdata !== 32'd0) begin miscompares++; $display("FAIL unmapped_read got %0h want 0", csr_rdata); end
    sw(OPW, A_FMT, 32'hF); step();
    vectors++; if (ivec_fmt !== 3'd7 || current_cycle !== 3'd0) begin
      miscompares++; $display("FAIL fmt_trunc got %0d/%0d want 7/0", ivec_fmt, current_cycle);
    end
    hw_we = 1'b1; hw_next = 3'd5; step();
    vectors++; if (current_cycle !== 3'd0) begin miscompares++; $display("FAIL fmt7_mask got %0d want 0", current_cycle); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; setback = 1'b0; csr_op = OPN; csr_addr = '0; csr_wdata = '0;
    hw_we = 1'b0; hw_next = '0; id_valid = 1'b0; ex_ready = 1'b0;
    test_reset();
    test_hw_cycle();
    test_cycle_mask();
    test_set_mask();
    test_priority();
    test_setback();
    test_skipsize();
    test_ex_cycle();
    test_back_to_back();
    test_unmapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
